// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV64I instruction fetch stage: PC, single-outstanding imem request, decode handshake
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [63:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_addr,
    output logic        inst_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nx;
    logic [63:0] pc, pc_nx;
    logic        drop, drop_nx;
    logic        load_word, load_nop;
    logic        aligned;

    assign aligned        = (pc[1:0] == 2'b00);
    assign imem_req_valid = (state == REQ) && aligned;
    assign imem_req_addr  = {pc[63:3], 3'b000};
    assign inst_valid     = (state == HOLD);

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        drop_nx   = drop;
        load_word = 1'b0;
        load_nop  = 1'b0;
        case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                if (!aligned) begin
                    load_nop = 1'b1;
                    state_nx = HOLD;
                end else if (imem_req_ready) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (drop) begin
                        drop_nx  = 1'b0;
                        state_nx = REQ;
                    end else begin
                        load_word = 1'b1;
                        pc_nx     = pc + 64'd4;
                        state_nx  = HOLD;
                    end
                end
            end
            HOLD: if (id_ready) state_nx = REQ;
            default: state_nx = IDLE;
        endcase

        // A redirect overrides everything; an accepted request still owes one response to discard.
        if (redirect_valid) begin
            pc_nx     = redirect_pc;
            load_word = 1'b0;
            load_nop  = 1'b0;
            case (state)
                REQ: begin
                    if (aligned && imem_req_ready) begin
                        state_nx = WAIT;
                        drop_nx  = 1'b1;
                    end else begin
                        state_nx = REQ;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state_nx = REQ;
                        drop_nx  = 1'b0;
                    end else begin
                        state_nx = WAIT;
                        drop_nx  = 1'b1;
                    end
                end
                default: state_nx = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            drop  <= drop_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst          <= 32'd0;
            inst_addr     <= 64'd0;
            inst_misalign <= 1'b0;
        end else if (load_word) begin
            inst          <= pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
            inst_addr     <= pc;
            inst_misalign <= 1'b0;
        end else if (load_nop) begin
            inst          <= NOP_INST;
            inst_addr     <= pc;
            inst_misalign <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and randomized bench for if_stage against a fetch-order model
module tb_if_stage;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [63:0] imem_resp_data = 64'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        id_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        inst_misalign;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_addr      (inst_addr),
        .inst_misalign  (inst_misalign)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_pc = RESET_PC;
    logic        mem_busy = 1'b0;
    logic [63:0] mem_addr = 64'd0;
    int          mem_lat = 0;
    int          lat_cfg = 0;
    logic        prev_redir = 1'b0;
    bit          model_on = 1'b0;
    int          seen_valid = 0;
    int          gap = 0;
    int          max_gap = 0;
    int          handshakes = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] mem_dw(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 64'hAAAA_BBBB_0000_0093;
        return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0] + 32'h1357_9BDF};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] p);
        logic [63:0] dw;
        if (p[1:0] != 2'b00) return NOP_INST;
        dw = mem_dw({p[63:3], 3'b000});
        return p[2] ? dw[63:32] : dw[31:0];
    endfunction

    // The model only tracks which PC decode must see next and what memory holds there.
    task automatic cyc(input logic r, input logic rdy, input logic idr, input logic rv,
                       input logic [63:0] rpc);
        logic hs, acc;
        if (model_on) begin
            if (inst_valid === 1'b1) begin
                seen_valid++;
                chk("inst_addr", inst_addr, exp_pc);
                chk("inst", 64'(inst), 64'(exp_inst(exp_pc)));
                chk("inst_misalign", 64'(inst_misalign), 64'(exp_pc[1:0] != 2'b00));
            end
            if (prev_redir) chk("valid_after_redirect", 64'(inst_valid), 64'd0);
            if (imem_req_valid === 1'b1) begin
                chk("req_addr", imem_req_addr, {exp_pc[63:3], 3'b000});
                chk("req_pc_aligned", 64'(exp_pc[1:0]), 64'd0);
            end
        end
        imem_resp_valid = mem_busy && (mem_lat == 0);
        imem_resp_data  = imem_resp_valid ? mem_dw(mem_addr) : {$urandom, $urandom};
        rst            = r;
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        hs  = (inst_valid === 1'b1) && idr;
        acc = (imem_req_valid === 1'b1) && rdy;
        if (hs) begin
            handshakes++;
            if (exp_pc[1:0] == 2'b00) exp_pc = exp_pc + 64'd4;
            gap = 0;
        end else begin
            gap++;
        end
        if (rv) exp_pc = rpc;
        if (imem_resp_valid) mem_busy = 1'b0;
        else if (mem_busy) mem_lat--;
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = imem_req_addr;
            mem_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        end
        prev_redir = rv;
        if (r) begin
            exp_pc     = RESET_PC;
            mem_busy   = 1'b0;
            prev_redir = 1'b0;
            gap        = 0;
        end
        if (gap > max_gap) max_gap = gap;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_inst();
        int n = 0;
        while (inst_valid !== 1'b1 && n < 30) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
            n++;
        end
        if (inst_valid !== 1'b1) chk("wait_inst_timeout", 64'(inst_valid), 64'd1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 30) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
            n++;
        end
        if (imem_req_valid !== 1'b1) chk("wait_req_timeout", 64'(imem_req_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_inst"}, 64'(inst), 64'd0);
        chk({tag, "_inst_addr"}, inst_addr, 64'd0);
        chk({tag, "_misalign"}, 64'(inst_misalign), 64'd0);
    endtask

    function automatic logic [63:0] rand_target();
        logic [31:0] off;
        off = 32'($urandom_range(0, 63)) << 3;
        if ($urandom_range(0, 7) == 0) off = off + 32'($urandom_range(1, 3));
        else if ($urandom_range(0, 1) == 1) off = off + 32'd4;
        return {32'd0, 32'h8000_0000 + off};
    endfunction

    initial begin
        int n;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        model_on = 1'b1;
        check_reset_outputs("reset");

        // First fetches from reset, memory always ready, one-cycle response.
        lat_cfg = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", imem_req_addr, 64'h8000_0000);
        wait_inst();
        chk("first_inst", 64'(inst), 64'h0000_0093);
        chk("first_inst_addr", inst_addr, 64'h8000_0000);
        repeat (5) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
            chk("bp_inst_valid", 64'(inst_valid), 64'd1);
            chk("bp_inst", 64'(inst), 64'h0000_0093);
            chk("bp_inst_addr", inst_addr, 64'h8000_0000);
            chk("bp_req_valid", 64'(imem_req_valid), 64'd0);
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        chk("second_req_valid", 64'(imem_req_valid), 64'd1);
        chk("second_req_addr", imem_req_addr, 64'h8000_0000);
        wait_inst();
        chk("second_inst", 64'(inst), 64'hAAAA_BBBB);
        chk("second_inst_addr", inst_addr, 64'h8000_0004);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        chk("third_req_addr", imem_req_addr, 64'h8000_0008);

        // Redirect while waiting; the late response must be dropped.
        lat_cfg = 3;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0100);
        seen_valid = 0;
        wait_req();
        chk("rw_no_inst", 64'(seen_valid), 64'd0);
        chk("rw_req_addr", imem_req_addr, 64'h8000_0100);
        lat_cfg = 0;
        wait_inst();
        chk("rw_inst_addr", inst_addr, 64'h8000_0100);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);

        // Redirect in the same cycle as the response.
        lat_cfg = 2;
        wait_req();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        n = 0;
        while (!(mem_busy && mem_lat == 0) && n < 10) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
            n++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0200);
        chk("rr_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rr_req_addr", imem_req_addr, 64'h8000_0200);

        // Redirect in the same cycle the request is accepted.
        lat_cfg = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0300);
        chk("ra_req_valid", 64'(imem_req_valid), 64'd0);
        seen_valid = 0;
        wait_req();
        chk("ra_no_inst", 64'(seen_valid), 64'd0);
        chk("ra_req_addr", imem_req_addr, 64'h8000_0300);
        wait_inst();
        chk("ra_inst_addr", inst_addr, 64'h8000_0300);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);

        // Misaligned target: NOP with misalign, repeated after each handshake.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0002);
        repeat (2) begin
            chk("mis_req_valid", 64'(imem_req_valid), 64'd0);
            wait_inst();
            chk("mis_inst", 64'(inst), 64'(NOP_INST));
            chk("mis_flag", 64'(inst_misalign), 64'd1);
            chk("mis_inst_addr", inst_addr, 64'h8000_0002);
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        end

        // PC increment wraps at 64 bits.
        wait_inst();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_inst();
        chk("wrap_inst_addr0", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
        wait_inst();
        chk("wrap_inst_addr1", inst_addr, 64'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);

        // Reset while a request is outstanding.
        lat_cfg = 3;
        wait_req();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        check_reset_outputs("rst_wait");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        chk("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("post_rst_req_addr", imem_req_addr, 64'h8000_0000);

        // Randomized traffic against the model.
        lat_cfg    = -1;
        max_gap    = 0;
        handshakes = 0;
        repeat (3000) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 19) == 0), rand_target());
        end
        chk("rand_progress", 64'(handshakes > 200), 64'd1);
        chk("rand_max_gap", 64'(max_gap <= 150), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
